// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ks_adder4.sv
// Combinational 4-bit Kogge-Stone adder slice with carry-in, exposing carry into bit 3.
module ks_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c3,
    output logic       cout
);

    logic [3:0] w_g0, w_p0;
    logic [3:0] w_g1, w_p1;
    logic [3:0] w_g2, w_p2;
    logic [4:0] w_c;

    assign w_g0 = a & b;
    assign w_p0 = a ^ b;

    // Prefix level 1 (distance 1)
    assign w_g1[0] = w_g0[0];
    assign w_p1[0] = w_p0[0];
    assign w_g1[3:1] = w_g0[3:1] | (w_p0[3:1] & w_g0[2:0]);
    assign w_p1[3:1] = w_p0[3:1] & w_p0[2:0];

    // Prefix level 2 (distance 2)
    assign w_g2[1:0] = w_g1[1:0];
    assign w_p2[1:0] = w_p1[1:0];
    assign w_g2[3:2] = w_g1[3:2] | (w_p1[3:2] & w_g1[1:0]);
    assign w_p2[3:2] = w_p1[3:2] & w_p1[1:0];

    // Fold the carry-in into each group prefix
    assign w_c[0]   = cin;
    assign w_c[4:1] = w_g2 | (w_p2 & {4{cin}});

    assign sum  = w_p0 ^ w_c[3:0];
    assign c3   = w_c[3];
    assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit Kogge-Stone slice, one nibble per cycle,
// with valid/ready handshakes on both operand and result sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned NIB  = WIDTH / NIBBLE;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_out_valid;

    logic [NIBBLE-1:0] w_a_nib;
    logic [NIBBLE-1:0] w_b_nib;
    logic [NIBBLE-1:0] w_sum_nib;
    logic              w_c3;
    logic              w_cout;

    // Select the current operand nibbles
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_a_nib = r_a[n*NIBBLE +: NIBBLE];
                w_b_nib = r_b[n*NIBBLE +: NIBBLE];
            end
        end
    end

    ks_adder4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum_nib),
        .c3   (w_c3),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (r_idx == IDXW'(n)) begin
                            r_sum[n*NIBBLE +: NIBBLE] <= w_sum_nib;
                        end
                    end
                    r_carry <= w_cout;
                    if (r_idx == IDXW'(NIB - 1)) begin
                        r_cout      <= w_cout;
                        r_ovf       <= w_c3 ^ w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; inputs ignored here
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) & ~rst;
    assign busy      = (r_state == RUN) | (r_state == DONE);
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

endmodule
